seq_div: RTL
============

# seq_div

Sequential restoring divider for the multiplier basic library, the arithmetic inverse of the array multipliers. It accepts an unsigned dividend/divisor pair on a start pulse and produces one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag with a one-cycle `done` pulse. Subtraction is built from a ripple chain of full-subtractor cells, mirroring the adder-cell construction used by the multipliers.

## Interface

- `WIDTH`, 8: operand, quotient and remainder width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `dividend`  in  WIDTH  unsigned dividend; sampled on an accepted `start`.
- `divisor`  in  WIDTH  unsigned divisor; sampled on an accepted `start`.
- `busy`  out  1  high while an iteration is in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `quotient`  out  WIDTH  unsigned quotient.
- `remainder`  out  WIDTH  unsigned remainder.
- `div_by_zero`  out  1  set with `done` when divisor was 0.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: results presented.
- Reset forces state IDLE. All outputs reset to 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`. The internal counter, partial remainder and divisor register also reset to 0.
- Accepted `start` is `start`=1 with state IDLE or DONE:
  - Latch the divisor.
  - Load the quotient shift register with `dividend`.
  - Clear the WIDTH+1-bit partial remainder `R` and the counter.
  - Clear `div_by_zero`.
- `start` in RUN is ignored and has no effect on the operation in flight.
- Divisor = 0 on an accepted start:
  - Skip RUN and go directly to DONE.
  - `quotient` = all ones, `remainder` = `dividend`, `div_by_zero` = 1.
- RUN step, once per cycle:
  - Shift: `Rs = {R[WIDTH-1:0], Q[WIDTH-1]}`, `Q = Q << 1`.
  - Compute `Rs − {0,divisor}` via the WIDTH+1-cell subtractor chain.
  - Borrow-out 0: `R` takes the difference and `Q[0]`=1.
  - Borrow-out 1: `R` takes `Rs` (restore) and `Q[0]`=0.
  - The counter increments; after WIDTH steps the state goes to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `quotient` = Q and `remainder` = `R[WIDTH-1:0]`; these hold unchanged until the next accepted start or reset.
  - The next state is IDLE, or RUN if `start`=1 (back-to-back).
- `R[WIDTH]` is always 0 after a step. The output remainder is always less than the divisor.

## Timing

- Edge E0 samples an accepted start (divisor ≠ 0). `busy`=1 for the cycles after E0 through E(WIDTH−1).
- After edge E(WIDTH): state DONE, `busy`=0, `done`=1. Latency is WIDTH+1 cycles from the start cycle to `done` (9 for WIDTH=8).
- Divide-by-zero: `done`=1 in the cycle after E0, i.e. latency 1. `busy` stays 0.
- Back-to-back: `start` held high in the DONE cycle begins a new operation. `done` then deasserts at the next edge, and the results of the previous operation remain on the outputs until the new DONE.
- Reset mid-RUN aborts the operation: the next cycle is IDLE with all outputs 0, and no `done` pulse is produced.
- `rst` and `start` in the same cycle: reset wins.
- The subtractor chain is combinational within one cycle, and its critical path is WIDTH+1 borrow stages. There is no pipelining.

## Structure

- Shared package `mult_pkg` holds:
  - the state enum `div_state_t` (IDLE, RUN, DONE);
  - the default width constant `MULT_WIDTH` = 8, used as the `WIDTH` default.
- Sub-module `fs`: a combinational full-subtractor cell.
  - Inputs `a`, `b`, `bin`; outputs `diff`, `bout`.
  - `diff` = a^b^bin; `bout` = (~a&b) | (~(a^b)&bin).
  - Instantiated WIDTH+1 times in a generate loop, with bit 0 `bin` = 0.
- `seq_div` contains the FSM, the counter of $clog2(WIDTH+1) bits, and the R, Q and divisor registers.

## Test plan

- 100 ÷ 7 (WIDTH=8) → `quotient`=14, `remainder`=2, `div_by_zero`=0; `done` exactly 9 cycles after the start cycle, `busy` high for 8 cycles.
- 255 ÷ 1 → 255 r 0; 3 ÷ 10 → 0 r 3; 200 ÷ 200 → 1 r 0; 0 ÷ 5 → 0 r 0.
- 5 ÷ 0 → `quotient`=0xFF, `remainder`=5, `div_by_zero`=1, `done` one cycle after start, `busy` never high.
- Start 100 ÷ 7, then assert `start` with 50 ÷ 3 at cycle 3 of RUN → ignored; result is 14 r 2. Then start 50 ÷ 3 in the DONE cycle → 16 r 2 after 9 more cycles.
- Reset asserted at cycle 4 of RUN → next cycle all outputs 0, no `done`. A new 9 ÷ 2 afterwards → 4 r 1.
- Random sweep: 10k random pairs with WIDTH=8 and WIDTH=16, checked against `/` and `%`. The checker verifies `remainder` < `divisor` and exactly one `done` pulse per accepted start.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the multiplier basic library
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/fs.sv
// rtl/fs.sv - combinational full-subtractor cell (a - b - bin)
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, one quotient bit per clock
module seq_div
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] borrow;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             last_step;
  logic             unused_r_msb;

  assign accept    = start && (state != RUN);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // R[WIDTH] is always 0 after a step, so it never feeds the shifted remainder
  assign unused_r_msb = r[WIDTH];

  assign rs        = {r[WIDTH-1:0], q[WIDTH-1]};
  assign sub_b     = {1'b0, dvs};
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    fs u_fs (
      .a    (rs[i]),
      .b    (sub_b[i]),
      .bin  (borrow[i]),
      .diff (diff[i]),
      .bout (borrow[i+1])
    );
  end

  // borrow out of the top cell means Rs < divisor: restore and shift in a 0
  assign r_step = borrow[WIDTH+1] ? rs : diff;
  assign q_step = {q[WIDTH-2:0], ~borrow[WIDTH+1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (divisor == '0) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // result registers only move on entering DONE, so back-to-back starts keep the old result visible
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      r           <= '0;
      q           <= dividend;
      dvs         <= divisor;
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      r   <= r_step;
      q   <= q_step;
      if (last_step) begin
        quotient  <= q_step;
        remainder <= r_step[WIDTH-1:0];
      end
    end
  end

endmodule
